fetch_sequencer: RTL

//   Program-counter / fetch sequencer feeding the instruction ROM, which in turn feeds the control decoder.

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and run/halt sequencer feeding the instruction ROM
// Selects the next PC each cycle (increment, jump, branch, halt) and counts run cycles.
module fetch_sequencer #(
  parameter int          PC_W = 10,
  parameter int          CT_W = 16,
  parameter int unsigned TGT0 = 0,
  parameter int unsigned TGT1 = 0,
  parameter int unsigned TGT2 = 0,
  parameter int unsigned TGT3 = 0
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_Start,
  input  logic [PC_W-1:0] i_StartAddr,
  input  logic            i_Jump,
  input  logic            i_BranchEn,
  input  logic [1:0]      i_TargSel,
  input  logic            i_CondFlag,
  input  logic            i_Ack,
  output logic [PC_W-1:0] o_ProgCtr,
  output logic            o_Running,
  output logic            o_Done,
  output logic [CT_W-1:0] o_CycleCt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [CT_W-1:0] r_ct;
  logic [CT_W-1:0] w_next_ct;
  logic [PC_W-1:0] w_targ;
  logic            w_take;

  // LUT entries wider than the PC keep only their low PC_W bits
  always_comb begin
    w_targ = '0;
    case (i_TargSel)
      2'd0:    w_targ = TGT0[PC_W-1:0];
      2'd1:    w_targ = TGT1[PC_W-1:0];
      2'd2:    w_targ = TGT2[PC_W-1:0];
      default: w_targ = TGT3[PC_W-1:0];
    endcase
  end

  assign w_take = i_Jump | (i_BranchEn & i_CondFlag);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ct    = r_ct;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_Start) begin
          w_next_state = S_LOAD;
          w_next_pc    = i_StartAddr;
          w_next_ct    = '0;
        end
      end
      S_LOAD: begin
        if (i_Start) begin
          w_next_pc = i_StartAddr;
          w_next_ct = '0;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (i_Start) begin
          w_next_state = S_LOAD;
          w_next_pc    = i_StartAddr;
          w_next_ct    = '0;
        end else begin
          // The halt cycle itself is still counted as a run cycle
          w_next_ct = (&r_ct) ? r_ct : r_ct + CT_W'(1);
          if (i_Ack) begin
            w_next_state = S_DONE;
          end else if (w_take) begin
            w_next_pc = w_targ;
          end else begin
            w_next_pc = r_pc + PC_W'(1);
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ct    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_ct    <= w_next_ct;
    end
  end

  assign o_ProgCtr = r_pc;
  assign o_CycleCt = r_ct;
  assign o_Running = (r_state == S_RUN);
  assign o_Done    = (r_state == S_DONE);

endmodule
